// File: rtl/intersections_pkg.sv
// Shared types and width helpers for the intersections job scheduler.
package intersections_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Widths depend on the core's coordinate width N, so they are functions of N.
    function automatic int g_w(input int n);
        return 3 * n + 1;
    endfunction

    function automatic int job_w(input int n);
        return 6 * n + 2;
    endfunction

    function automatic int o_w(input int n);
        return 14 * n + 34;
    endfunction

    function automatic int lat_def(input int n);
        return 3 * n + 13;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index after `last_i` (mod R) wins.
module rr_arbiter #(
    parameter int R = 2
) (
    input  logic [R-1:0]         req_i,
    input  logic [$clog2(R)-1:0] last_i,
    input  logic                 en_i,
    output logic [R-1:0]         gnt_o,
    output logic [$clog2(R)-1:0] idx_o,
    output logic                 any_o
);

    localparam int ID_W = $clog2(R);

    logic [ID_W-1:0] cand;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= R; k++) begin
            cand = ID_W'((int'(last_i) + k) % R);
            if (en_i && !any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersections_sched.sv
// Shares one intersections core between R requesters: arbitrate, load, run LAT cycles, return result.
// Optional statistics counters are built when INTERSECTIONS_SCHED_STATS_EN is defined.
module intersections_sched
    import intersections_pkg::*;
#(
    parameter int N   = 8,
    parameter int R   = 2,
    parameter int LAT = lat_def(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [R-1:0]             req_valid,
    output logic [R-1:0]             req_ready,
    input  logic [R*job_w(N)-1:0]    req_job,
    output logic                     core_rst,
    output logic [g_w(N)-1:0]        core_g,
    output logic [g_w(N)-1:0]        core_e,
    input  logic [o_w(N)-1:0]        core_o,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [o_w(N)-1:0]        res_data,
    output logic [$clog2(R)-1:0]     res_id,
    output logic                     busy
`ifdef INTERSECTIONS_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_jobs,
    output logic [31:0]              stat_busy
`endif
);

    localparam int G_W   = g_w(N);
    localparam int JOB_W = job_w(N);
    localparam int O_W   = o_w(N);
    localparam int ID_W  = $clog2(R);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [G_W-1:0]   core_g_q, core_g_d;
    logic [G_W-1:0]   core_e_q, core_e_d;
    logic             core_rst_q, core_rst_d;
    logic             res_valid_q, res_valid_d;
    logic [O_W-1:0]   res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;

    logic             arb_en;
    logic [R-1:0]     arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic [JOB_W-1:0] job_sel;

    // Grants are suppressed while reset is asserted so no ready pulse escapes.
    assign arb_en  = (state_q == IDLE) && rst;
    assign job_sel = req_job[arb_idx*JOB_W +: JOB_W];

    rr_arbiter #(.R(R)) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        core_g_d    = core_g_q;
        core_e_d    = core_e_q;
        core_rst_d  = core_rst_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    core_g_d   = job_sel[JOB_W-1:G_W];
                    core_e_d   = job_sel[G_W-1:0];
                    res_id_d   = arb_idx;
                    last_d     = arb_idx;
                    core_rst_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                core_rst_d = 1'b0;
                cnt_d      = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    res_data_d  = core_o;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // core_rst stays high from system reset until the first job's LOAD cycle ends.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(R - 1);
            cnt_q       <= '0;
            core_g_q    <= '0;
            core_e_q    <= '0;
            core_rst_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            core_g_q    <= core_g_d;
            core_e_q    <= core_e_d;
            core_rst_q  <= core_rst_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign req_ready = arb_gnt;
    assign core_rst  = core_rst_q;
    assign core_g    = core_g_q;
    assign core_e    = core_e_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

`ifdef INTERSECTIONS_SCHED_STATS_EN
    logic [15:0] stat_jobs_q;
    logic [31:0] stat_busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_jobs_q <= '0;
            stat_busy_q <= '0;
        end else begin
            if (res_valid_q && res_ready && (stat_jobs_q != 16'hFFFF)) begin
                stat_jobs_q <= stat_jobs_q + 16'd1;
            end
            if (busy) begin
                stat_busy_q <= stat_busy_q + 32'd1;
            end
        end
    end

    assign stat_jobs = stat_jobs_q;
    assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_intersections_sched.sv
// Self-checking bench for intersections_sched with a stand-in core and a round-robin reference model.
module tb_intersections_sched;

    localparam int N     = 8;
    localparam int R     = 2;
    localparam int LAT   = 3 * N + 13;
    localparam int G_W   = 3 * N + 1;
    localparam int JOB_W = 6 * N + 2;
    localparam int O_W   = 14 * N + 34;
    localparam int ID_W  = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [R-1:0]       req_valid;
    logic [R-1:0]       req_ready;
    logic [R*JOB_W-1:0] req_job;
    logic               core_rst;
    logic [G_W-1:0]     core_g;
    logic [G_W-1:0]     core_e;
    logic [O_W-1:0]     core_o;
    logic               res_valid;
    logic               res_ready;
    logic [O_W-1:0]     res_data;
    logic [ID_W-1:0]    res_id;
    logic               busy;
`ifdef INTERSECTIONS_SCHED_STATS_EN
    logic [15:0]        stat_jobs;
    logic [31:0]        stat_busy;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int last_m   = R - 1;

    intersections_sched #(.N(N), .R(R), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_job   (req_job),
        .core_rst  (core_rst),
        .core_g    (core_g),
        .core_e    (core_e),
        .core_o    (core_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
`ifdef INTERSECTIONS_SCHED_STATS_EN
        ,
        .stat_jobs (stat_jobs),
        .stat_busy (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in core: the golden value appears only on the LAT-th cycle after reset release.
    int unsigned core_cyc = 0;
    always @(posedge clk) begin
        if (core_rst) core_cyc <= 0;
        else if (core_cyc < 10000) core_cyc <= core_cyc + 1;
    end

    function automatic logic [O_W-1:0] golden(input logic [G_W-1:0] g, input logic [G_W-1:0] e);
        logic [63:0] s;
        s = 64'(g) * 64'd7 + 64'(e);
        return {s[45:0], g, e, g ^ e, ~e};
    endfunction

    assign core_o = (core_cyc == LAT - 1) ? golden(core_g, core_e) : ~golden(core_g, core_e);

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int rr_pick(input logic [R-1:0] v);
        for (int k = 1; k <= R; k++) begin
            if (v[(last_m + k) % R]) return (last_m + k) % R;
        end
        return -1;
    endfunction

    function automatic logic [JOB_W-1:0] rand_job();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[JOB_W-1:0];
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"}, req_ready, '0);
        check({pfx, "_res_valid"}, res_valid, 1'b0);
        check({pfx, "_res_data"},  res_data,  '0);
        check({pfx, "_res_id"},    res_id,    '0);
        check({pfx, "_busy"},      busy,      1'b0);
        check({pfx, "_core_rst"},  core_rst,  1'b1);
        check({pfx, "_core_g"},    core_g,    '0);
        check({pfx, "_core_e"},    core_e,    '0);
`ifdef INTERSECTIONS_SCHED_STATS_EN
        check({pfx, "_stat_jobs"}, stat_jobs, '0);
        check({pfx, "_stat_busy"}, stat_busy, '0);
`endif
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        #1;
        check_reset_vals("reset");
        rst    = 1'b1;
        last_m = R - 1;
    endtask

    // One complete job from grant to handshake; returns granted index and cycles waited.
    task automatic do_job(input bit requeue, input int bp, output int gid, output int waited);
        logic [JOB_W-1:0] job;
        logic [O_W-1:0]   exp_o;
        int               exp_id;
        int               bad;
        gid    = -1;
        waited = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < R; i++) if (req_ready[i]) gid = i;
                break;
            end
            tick();
            waited++;
        end
        if (gid < 0) begin
            check("grant_seen", |req_ready, 1'b1);
            return;
        end
        check("req_ready_onehot", $onehot(req_ready), 1'b1);
        exp_id = rr_pick(req_valid);
        check("grant_idx", gid, exp_id);
        if (exp_id >= 0) last_m = exp_id;
        job   = req_job[gid*JOB_W +: JOB_W];
        exp_o = golden(job[JOB_W-1:G_W], job[G_W-1:0]);

        tick();
        if (requeue) req_job[gid*JOB_W +: JOB_W] = rand_job();
        else         req_valid[gid] = 1'b0;
        #1;
        check("load_core_rst", core_rst, 1'b1);
        check("load_busy", busy, 1'b1);
        check("load_core_g", core_g, job[JOB_W-1:G_W]);
        check("load_core_e", core_e, job[G_W-1:0]);
        check("load_req_ready", req_ready, '0);

        bad = 0;
        repeat (LAT) begin
            tick();
            #1;
            if (core_rst !== 1'b0 || res_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b1) bad++;
        end
        check("run_window", bad, 0);

        tick();
        #1;
        check("res_valid_rise", res_valid, 1'b1);
        check("res_data", res_data, exp_o);
        check("res_id", res_id, gid);

        if (bp > 0) begin
            bad = 0;
            for (int k = 0; k < bp; k++) begin
                tick();
                #1;
                if (res_valid !== 1'b1 || res_data !== exp_o || res_id !== ID_W'(gid) ||
                    req_ready !== '0 || busy !== 1'b1) bad++;
            end
            check("bp_stable", bad, 0);
            res_ready = 1'b1;
        end

        tick();
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_res_valid", res_valid, 1'b0);
        if (bp > 0) res_ready = 1'b0;
    endtask

    initial begin
        int g, w, bad;
        int order[4];
        int waits[4];

        rst       = 1'b0;
        req_valid = '0;
        req_job   = '0;
        res_ready = 1'b1;
        tick();
        apply_reset();

        // Single job with the reference anchor values on requester 0.
        req_job[0 +: JOB_W] = {1'b0, 8'hF0, 8'h91, 8'hEC, 1'b0, 8'h6D, 8'h9D, 8'hB7};
        req_valid[0] = 1'b1;
        do_job(1'b0, 0, g, w);
        check("single_gid", g, 0);
        check("single_wait", w, 0);

        // Both requesters valid right after reset: grants alternate back to back.
        apply_reset();
        req_job[0 +: JOB_W]     = rand_job();
        req_job[JOB_W +: JOB_W] = rand_job();
        req_valid = '1;
        do_job(1'b1, 0, order[0], waits[0]);
        do_job(1'b1, 0, order[1], waits[1]);
        do_job(1'b0, 0, order[2], waits[2]);
        do_job(1'b0, 0, order[3], waits[3]);
        check("rot_order0", order[0], 0);
        check("rot_order1", order[1], 1);
        check("rot_order2", order[2], 0);
        check("rot_order3", order[3], 1);
        check("rot_back2back", waits[1] + waits[2] + waits[3], 0);

        // Backpressure with a competing request pending throughout DONE.
        res_ready = 1'b0;
        req_job[0 +: JOB_W]     = rand_job();
        req_job[JOB_W +: JOB_W] = rand_job();
        req_valid = '1;
        do_job(1'b0, 10, g, w);
        check("bp_gid", g, 0);
        res_ready = 1'b1;
        do_job(1'b0, 0, g, w);
        check("bp_next_gid", g, 1);

        // Reset at RUN cnt=20 abandons the job.
        req_job[JOB_W +: JOB_W] = rand_job();
        req_valid[1] = 1'b1;
        #1;
        check("abort_grant", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        repeat (21) tick();
        #1;
        check("abort_in_run", busy, 1'b1);
        rst = 1'b0;
        tick();
        #1;
        check_reset_vals("midrun");
        rst    = 1'b1;
        last_m = R - 1;
        bad = 0;
        repeat (LAT + 5) begin
            tick();
            #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_result", bad, 0);
        req_job[JOB_W +: JOB_W] = rand_job();
        req_valid[1] = 1'b1;
        do_job(1'b0, 0, g, w);
        check("post_reset_gid", g, 1);

        // Randomised traffic with random backpressure.
        for (int it = 0; it < 10; it++) begin
            int bpr;
            for (int i = 0; i < R; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_job[i*JOB_W +: JOB_W] = rand_job();
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                req_job[0 +: JOB_W] = rand_job();
                req_valid[0] = 1'b1;
            end
            bpr       = $urandom_range(0, 3);
            res_ready = (bpr == 0);
            do_job(1'b0, bpr, g, w);
        end
        res_ready = 1'b1;
        for (int d = 0; d < R && req_valid != '0; d++) do_job(1'b0, 0, g, w);

`ifdef INTERSECTIONS_SCHED_STATS_EN
        apply_reset();
        req_job[0 +: JOB_W] = rand_job();
        req_valid[0] = 1'b1;
        do_job(1'b1, 0, g, w);
        do_job(1'b1, 0, g, w);
        do_job(1'b0, 0, g, w);
        check("stat_jobs", stat_jobs, 16'd3);
        check("stat_busy", stat_busy, 32'd3 * 32'(LAT + 2));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/intersections_sched.md
# intersections_sched

Job scheduler and sequencer for the `intersections` circle-intersection core. It shares one core instance between `R` requesters using round-robin arbitration. For each job it latches the two anchor descriptors, pulses the core's reset, and counts the fixed evaluation latency. It then captures the packed intersection result and returns it, tagged with the requester index, over a valid/ready result port.

## Interface
Parameters:
- `N`, 8: coordinate width, matching the core's `N`.
- `R`, 2: number of requesters, ≥ 2.
- `LAT`, 3*N+13: core evaluation cycles from core reset release to a valid `o`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in R: per-requester job valid.
- `req_ready` out R: per-requester accept. One-hot or zero.
- `req_job` in R*(6N+2): per-requester job. Slice i is {g_init[3N:0], e_init[3N:0]}, with g in the upper half.
- `core_rst` out 1: active-high reset to the core.
- `core_g` out 3N+1: drives the core's `g_init`.
- `core_e` out 3N+1: drives the core's `e_init`.
- `core_o` in 14N+34: core output {x1D, y1D, x2D, y2D}.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accept.
- `res_data` out 14N+34: captured `core_o`.
- `res_id` out clog2(R): index of the requester that owns the result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States are IDLE, LOAD, RUN and DONE.
- **IDLE**
  - If any `req_valid` is high, grant index g by round-robin and pulse `req_ready[g]` for that cycle.
  - Latch the job into `core_g`/`core_e` and g into `res_id`, then go to LOAD.
- **LOAD**
  - `core_rst`=1 for exactly one cycle, with the latched inputs stable. Go to RUN and clear `cnt`.
- **RUN**
  - `core_rst`=0 and `cnt` increments each cycle.
  - When `cnt`==LAT-1: capture `core_o` into `res_data`, set `res_valid`, go to DONE.
- **DONE**
  - Hold `res_valid`, `res_data` and `res_id` stable until `res_valid && res_ready`.
  - Then clear `res_valid` and go to IDLE.
- Round-robin rule:
  - The search starts at `last+1` mod R; the lowest index after `last` wins.
  - `last` updates only on grant.
- Outside IDLE, `req_ready` is 0.
- `core_g` and `core_e` change only on grant; they hold their value through DONE.
- `cnt` is clog2(LAT) bits wide and never wraps within RUN.

## Timing
- Reset (`rst`=0 at an edge) gives:
  - state=IDLE, `last`=R-1 (requester 0 has first priority);
  - `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0;
  - `core_rst`=1, `core_g`=0, `core_e`=0.
- Reset mid-RUN or in DONE abandons the job without emitting a result. The first post-reset job starts clean.
- Latency:
  - Accept at cycle t, LOAD at t+1, RUN from t+2 to t+1+LAT.
  - `res_valid` is first high at t+2+LAT, i.e. LAT+2 cycles after accept.
- Throughput: at best one job per LAT+3 cycles. IDLE always costs one cycle after the DONE handshake.
- Requester side: a requester must hold `req_valid` and `req_job` until it sees `req_ready`. Dropping `req_valid` before grant is legal.
- Handshake boundaries:
  - `res_ready` high on the first DONE cycle completes in zero extra cycles.
  - `res_ready` asserted before `res_valid` has no effect.
- All requesters valid simultaneously: grants rotate, and no requester waits more than R-1 jobs.

## Configuration
- Macro: `INTERSECTIONS_SCHED_STATS_EN`.
- With it defined, two extra outputs are present:
  - `stat_jobs` (16 bits, saturating): increments on each result handshake.
  - `stat_busy` (32 bits, wrapping): increments every cycle `busy`=1.
  - Both reset to 0.
- Without it, these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `intersections_pkg` holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - width constants G_W=3N+1, JOB_W=6N+2, O_W=14N+34;
  - the default LAT expression.
- One sub-module, `rr_arbiter`, parameterised on R:
  - inputs: request vector, `last`, and an enable;
  - outputs: one-hot grant and the encoded index.
- The FSM, counter and capture registers stay in `intersections_sched`.

## Test plan
- **Single job.**
  - Stimulus: N=8, LAT=37; requester 0 job xB=-16, yB=-111, rB=236, xC=109, yC=-99, rC=183; `res_ready` held high.
  - Expected: `req_ready[0]` at t; `core_rst` high only at t+1; `res_valid` at t+39; `res_data` equals the core golden model; `res_id`=0.
- **Simultaneous requests.**
  - Stimulus: requesters 0 and 1 both valid right after reset.
  - Expected: grant order 0, 1, 0, 1; each requester's second grant follows exactly one other job.
- **Backpressure.**
  - Stimulus: `res_ready` low for 10 cycles after `res_valid` rises.
  - Expected: `res_data` and `res_id` stable; no `req_ready` pulse; IDLE is entered the cycle after the handshake.
- **Reset mid-RUN.**
  - Stimulus: `rst`=0 at RUN `cnt`=20.
  - Expected: next cycle shows the reset values listed under Timing; no `res_valid`; a new job completes with the correct result.
- **Stats (`INTERSECTIONS_SCHED_STATS_EN` defined).**
  - Stimulus: 3 back-to-back jobs with `res_ready` high.
  - Expected: `stat_jobs`=3 and `stat_busy`=3*39=117.
